sync_fifo_param: RTL

- Parametrised synchronous single-clock FIFO. Successor to the fixed 8-deep FIFO.
- Generalised in data width and depth; depth need not be a power of two.
- Almost-full and almost-empty thresholds are set by parameters.
- Exposes its occupancy count and, optionally, a peak-occupancy watermark. Sits between a producer and a consumer in the datapath.

---
 rtl/sync_fifo_param_if.sv | 45 ++++
 rtl/sync_fifo_param.sv | 102 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// SYNC_FIFO_WATERMARK_EN adds the peak-occupancy watermark signals.
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int CW     = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              almostfull;
  logic              almostempty;
  logic [CW-1:0]     count;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic              wm_clr;
  logic [CW-1:0]     peak_count;

  modport master (
    output wr_en, data_in, rd_en, wm_clr,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, peak_count
  );
  modport slave (
    input  wr_en, data_in, rd_en, wm_clr,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, peak_count
  );
`else
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO, any depth 2..1024, with threshold flags.
// Define SYNC_FIFO_WATERMARK_EN to add peak_count / wm_clr watermark tracking.
module sync_fifo_param #(
  parameter  int DATA_W   = 16,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);

  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH=%0d outside 2..1024", DEPTH);
  end
  if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH - 1)) begin : g_bad_levels
    $error("sync_fifo_param: need 1 <= AE_LEVEL(%0d) < AF_LEVEL(%0d) <= DEPTH-1", AE_LEVEL, AF_LEVEL);
  end

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, next_count;
  logic [DATA_W-1:0] data_out_q;
  logic              wr_ack_q, overflow_q, underflow_q;
  logic              wr_ok, rd_ok;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Both accept decisions use the pre-edge count, even when requests coincide.
  assign wr_ok = bus.wr_en && (count_q != FULL_CNT);
  assign rd_ok = bus.rd_en && (count_q != '0);

  always_comb begin
    // NOTE: default first so every path assigns next_count and no latch is inferred.
    next_count = count_q;
    if (wr_ok && !rd_ok)      next_count = count_q + 1'b1;
    else if (rd_ok && !wr_ok) next_count = count_q - 1'b1;
  end

  // NOTE: storage has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wr_ptr] <= bus.data_in;
  end

  // NOTE: non-blocking everywhere here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= next_count;
      wr_ack_q    <= wr_ok;
      overflow_q  <= bus.wr_en && !wr_ok;
      underflow_q <= bus.rd_en && !rd_ok;
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        data_out_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == FULL_CNT);
  assign bus.empty       = (count_q == '0);
  assign bus.almostfull  = (count_q >= AF_CNT) && (count_q < FULL_CNT);
  assign bus.almostempty = (count_q != '0) && (count_q <= AE_CNT);

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CW-1:0] peak_q;

  // Clear reloads from the post-edge occupancy rather than zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                    peak_q <= '0;
    else if (bus.wm_clr)           peak_q <= next_count;
    else if (next_count > peak_q)  peak_q <= next_count;
  end

  assign bus.peak_count = peak_q;
`endif

endmodule
